dcm_lock_arbiter: RTL and testbench
===================================

Name: dcm_lock_arbiter

Overview:
- Parametrised clock-source arbiter for N_SRC DCM/PLL outputs; next generation of the two-input lock-based frequency select.
- Synchronises and debounces each lock flag, picks the highest-index locked source, and enforces a hold-off time after every switch.
- Reports selection validity and switch events.
- Its f_select output drives the downstream clock mux / BUFGMUX select in the sync chain.

Parameters:
- N_SRC, 2, number of candidate sources (2..8).
- SEL_W, 1, width of f_select; must satisfy 2**SEL_W >= N_SRC.
- LOCK_FILT, 16, consecutive synchronised-high cycles required before a source counts as locked (1..255).
- HOLDOFF, 64, minimum cycles in HOLD after a switch before a priority revert is allowed (1..65535).

Ports:
- clk  in  1  system clock; must be free-running and independent of the arbitrated sources.
- rst_n  in  1  asynchronous active-low reset.
- locked  in  N_SRC  raw lock flags, asynchronous to clk; bit i belongs to source i.
- f_select  out  SEL_W  selected source index.
- sel_valid  out  1  high while the selected source is filtered-locked.
- switch_pulse  out  1  one-cycle pulse on every change of f_select or selection start.
- none_locked  out  1  high when no source is filtered-locked.

Behaviour:
- Reset values (async assert, sync deassert via internal 2-FF release): f_select=0, sel_valid=0, switch_pulse=0, none_locked=1. All sync FFs, filter counters and hold-off counter are 0; state=IDLE.
- Sync: each locked[i] passes through a 2-FF synchroniser (s[i]).
- Filter, per channel: 8-bit cnt[i].
  - s[i]=1: cnt[i] increments, saturating at LOCK_FILT.
  - s[i]=0: cnt[i] clears.
  - filt[i] = (cnt[i]==LOCK_FILT) & s[i]. Lock loss is therefore seen immediately after the synchroniser.
- best = highest index i with filt[i]=1. Ties are impossible; higher index has higher priority.
- FSM states: IDLE, HOLD, RUN. hcnt is 16 bits.
- IDLE:
  - Outputs: sel_valid=0, none_locked=1; f_select keeps its last value.
  - If any filt: f_select<=best, switch_pulse=1, hcnt<=HOLDOFF-1, go to HOLD.
- HOLD:
  - Outputs: sel_valid=1, none_locked=0.
  - If filt[f_select]=0 and another source is locked: switch to best immediately, switch_pulse=1, reload hcnt, stay in HOLD. Lock loss overrides hold-off.
  - If filt[f_select]=0 and nothing is locked: go to IDLE.
  - Else if hcnt==0: go to RUN.
  - Else: hcnt decrements.
- RUN:
  - Outputs: sel_valid=1, none_locked=0.
  - On loss of the current source: same handling as in HOLD.
  - If best > f_select: revert per LOCK_REVERT_EN.
- Simultaneous events: if current-source loss and a higher-priority lock occur in the same cycle, loss handling wins (switch to best). One switch per cycle at most.
- Latency:
  - Raw locked rise to f_select/switch_pulse: LOCK_FILT+3 clk edges when the FSM is idle.
  - Raw locked fall to reaction: 3 clk edges.
- A lock glitch shorter than LOCK_FILT cycles never causes a switch but does restart that channel's filter.
- Reset mid-HOLD/RUN: outputs return to reset values asynchronously; re-acquisition starts from the filter.
- switch_pulse is never high two cycles in a row.

Optional Feature:
- Macro: LOCK_REVERT_EN.
- Defined (revertive): in RUN, if best > f_select, then f_select<=best, switch_pulse=1, hcnt reload, go to HOLD.
- Undefined (non-revertive): the arbiter stays on the current source until it loses lock. Higher-priority locks are ignored while the current source is locked.
- Loss handling is identical in both builds.

Test Plan (N_SRC=2, LOCK_FILT=4, HOLDOFF=8 unless stated):
- Reset release, locked=00 for 50 clk -> f_select=0, sel_valid=0, none_locked=1, switch_pulse never asserted.
- locked[0] rises -> exactly 7 clk later f_select=0, sel_valid=1, none_locked=0, one switch_pulse. 3-cycle high glitch on locked[1] -> no switch.
- locked[0]=1 in RUN, locked[1] rises:
  - LOCK_REVERT_EN: f_select=1 after 7 clk with a switch_pulse.
  - Without LOCK_REVERT_EN: f_select stays 0.
- f_select=1, locked[1] drops 2 clk after a switch (inside HOLD), locked[0]=1 -> f_select=0 at 3 clk, one pulse. Both drop -> sel_valid=0, none_locked=1 at 3 clk.
- N_SRC=4, SEL_W=2, locked=1011 stable -> f_select=3. Drop bit 3 -> f_select=1 (highest remaining).
- Assert rst_n=0 while in HOLD -> outputs immediately f_select=0, sel_valid=0, none_locked=1, switch_pulse=0.

Source files
------------

// File: rtl/dcm_lock_arbiter.sv
// dcm_lock_arbiter: picks one of N_SRC DCM/PLL outputs by lock state.
// Each raw lock flag is synchronised and debounced. The highest-index
// locked source wins, and a hold-off period follows every switch.
// Optional build macro LOCK_REVERT_EN: when defined, the arbiter reverts
// to a higher-priority source once the hold-off has expired. When
// undefined, it stays on the current source until that source loses lock.
module dcm_lock_arbiter #(
  parameter int N_SRC     = 2,
  parameter int SEL_W     = 1,
  parameter int LOCK_FILT = 16,
  parameter int HOLDOFF   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] locked,
  output logic [SEL_W-1:0] f_select,
  output logic             sel_valid,
  output logic             switch_pulse,
  output logic             none_locked
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

  localparam logic [7:0]       FILT_MAX  = 8'(LOCK_FILT);
  localparam logic [15:0]      HOLD_LOAD = 16'(HOLDOFF - 1);
  localparam logic [N_SRC-1:0] ONE_HOT0  = {{(N_SRC-1){1'b0}}, 1'b1};

  logic [1:0]            rst_sync;
  logic                  run_en;
  logic [N_SRC-1:0]      meta;
  logic [N_SRC-1:0]      s;
  logic [N_SRC-1:0][7:0] cnt;
  logic [N_SRC-1:0]      filt;
  logic [SEL_W-1:0]      best;
  logic                  any_lock;
  logic                  cur_ok;
  state_t                state, state_n;
  logic [SEL_W-1:0]      sel_n;
  logic [15:0]           hcnt, hcnt_n;
  logic                  pulse_n;

  // Reset release synchroniser: reset asserts at once, and the logic leaves reset two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run_en = rst_sync[1];

  // Two-flop synchroniser for each asynchronous lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      s    <= '0;
    end else if (!run_en) begin
      meta <= '0;
      s    <= '0;
    end else begin
      meta <= locked;
      s    <= meta;
    end
  end

  // Per-channel debounce counters: count consecutive high cycles, saturate, and clear on any low cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run_en) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!s[i])                  cnt[i] <= 8'd0;
        else if (cnt[i] != FILT_MAX) cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  // Filtered lock flags and the highest-priority locked source
  always_comb begin
    filt = '0;
    best = '0;
    for (int i = 0; i < N_SRC; i++) begin
      filt[i] = (cnt[i] == FILT_MAX) && s[i];
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (filt[i]) best = SEL_W'(i);
    end
  end

  assign any_lock = |filt;
  assign cur_ok   = |(filt & (ONE_HOT0 << f_select));

  // State register plus the selection, hold-off counter and registered switch pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      f_select     <= '0;
      hcnt         <= '0;
      switch_pulse <= 1'b0;
    end else if (!run_en) begin
      state        <= IDLE;
      f_select     <= '0;
      hcnt         <= '0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      f_select     <= sel_n;
      hcnt         <= hcnt_n;
      switch_pulse <= pulse_n;
    end
  end

  // Next-state logic. A switch is deferred by one cycle when the previous cycle already switched, so the pulse never repeats back to back
  always_comb begin
    state_n = state;
    sel_n   = f_select;
    hcnt_n  = hcnt;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (any_lock) begin
          sel_n   = best;
          pulse_n = 1'b1;
          hcnt_n  = HOLD_LOAD;
          state_n = HOLD;
        end
      end
      HOLD, RUN: begin
        if (!cur_ok) begin
          if (!any_lock) begin
            state_n = IDLE;
          end else if (!switch_pulse) begin
            sel_n   = best;
            pulse_n = 1'b1;
            hcnt_n  = HOLD_LOAD;
            state_n = HOLD;
          end
        end else if (state == HOLD) begin
          if (hcnt == 16'd0) state_n = RUN;
          else               hcnt_n  = hcnt - 16'd1;
        end
`ifdef LOCK_REVERT_EN
        else if ((best > f_select) && !switch_pulse) begin
          sel_n   = best;
          pulse_n = 1'b1;
          hcnt_n  = HOLD_LOAD;
          state_n = HOLD;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign sel_valid   = (state != IDLE);
  assign none_locked = (state == IDLE);

endmodule

// File: tb/tb_dcm_lock_arbiter.sv
// Testbench for dcm_lock_arbiter: a 2-source and a 4-source instance
// are run against a behavioural lock/hold-off model, with directed steps
// followed by randomised lock activity.
module tb_dcm_lock_arbiter;

  localparam int LF = 4;
  localparam int HO = 8;
`ifdef LOCK_REVERT_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_RUN  = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] locked2;
  logic [3:0] locked4;
  logic       d2_sel;
  logic       d2_valid, d2_pulse, d2_none;
  logic [1:0] d4_sel;
  logic       d4_valid, d4_pulse, d4_none;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, one entry per instance: raw lock history and run lengths, plus the arbitration mode
  int       m_n[2];
  bit [3:0] m_s1[2];
  bit [3:0] m_s2[2];
  int       m_run[2][4];
  int       m_mode[2];
  int       m_sel[2];
  int       m_left[2];
  bit       m_pulse[2];

  dcm_lock_arbiter #(.N_SRC(2), .SEL_W(1), .LOCK_FILT(LF), .HOLDOFF(HO)) dut2 (
    .clk(clk), .rst_n(rst_n), .locked(locked2), .f_select(d2_sel),
    .sel_valid(d2_valid), .switch_pulse(d2_pulse), .none_locked(d2_none)
  );

  dcm_lock_arbiter #(.N_SRC(4), .SEL_W(2), .LOCK_FILT(LF), .HOLDOFF(HO)) dut4 (
    .clk(clk), .rst_n(rst_n), .locked(locked4), .f_select(d4_sel),
    .sel_valid(d4_valid), .switch_pulse(d4_pulse), .none_locked(d4_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_n[0] = 2;
    m_n[1] = 4;
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0;
      m_s2[k] = '0;
      for (int i = 0; i < 4; i++) m_run[k][i] = 0;
      m_mode[k]  = M_IDLE;
      m_sel[k]   = 0;
      m_left[k]  = 0;
      m_pulse[k] = 1'b0;
    end
  endtask

  // One clock of the reference model, fed with the raw flags present at the edge
  task automatic modelStep(input int k, input bit [3:0] raw);
    bit [3:0] lk;
    int       best;
    bit       prev_pulse;
    bit       do_switch;
    lk   = '0;
    best = 0;
    for (int i = 0; i < m_n[k]; i++) begin
      if (m_s2[k][i] && (m_run[k][i] >= LF)) lk[i] = 1'b1;
    end
    for (int i = 0; i < m_n[k]; i++) if (lk[i]) best = i;
    prev_pulse = m_pulse[k];
    m_pulse[k] = 1'b0;
    do_switch  = 1'b0;
    if (m_mode[k] == M_IDLE) begin
      do_switch = (lk != 0);
    end else if (!lk[m_sel[k]]) begin
      if (lk == 0) m_mode[k] = M_IDLE;
      else         do_switch = !prev_pulse;
    end else if (m_mode[k] == M_HOLD) begin
      if (m_left[k] == 0) m_mode[k] = M_RUN;
      else                m_left[k] = m_left[k] - 1;
    end else if (REV && (best > m_sel[k]) && !prev_pulse) begin
      do_switch = 1'b1;
    end
    if (do_switch) begin
      m_sel[k]   = best;
      m_pulse[k] = 1'b1;
      m_left[k]  = HO - 1;
      m_mode[k]  = M_HOLD;
    end
    for (int i = 0; i < m_n[k]; i++) begin
      m_run[k][i] = m_s2[k][i] ? m_run[k][i] + 1 : 0;
      m_s2[k][i]  = m_s1[k][i];
      m_s1[k][i]  = raw[i];
    end
  endtask

  task automatic checkAll();
    checkOutput("d2.f_select",     32'(d2_sel),   32'(m_sel[0]));
    checkOutput("d2.sel_valid",    32'(d2_valid), 32'(m_mode[0] != M_IDLE));
    checkOutput("d2.none_locked",  32'(d2_none),  32'(m_mode[0] == M_IDLE));
    checkOutput("d2.switch_pulse", 32'(d2_pulse), 32'(m_pulse[0]));
    checkOutput("d4.f_select",     32'(d4_sel),   32'(m_sel[1]));
    checkOutput("d4.sel_valid",    32'(d4_valid), 32'(m_mode[1] != M_IDLE));
    checkOutput("d4.none_locked",  32'(d4_none),  32'(m_mode[1] == M_IDLE));
    checkOutput("d4.switch_pulse", 32'(d4_pulse), 32'(m_pulse[1]));
  endtask

  // Drive both instances for one clock, advance the model, then compare just after the edge
  task automatic applyStimulus(input bit [1:0] l2, input bit [3:0] l4, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      locked2 = l2;
      locked4 = l4;
      @(posedge clk);
      modelStep(0, {2'b00, l2});
      modelStep(1, l4);
      #1;
      checkAll();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".d2.f_select"},     32'(d2_sel),   32'd0);
    checkOutput({tag, ".d2.sel_valid"},    32'(d2_valid), 32'd0);
    checkOutput({tag, ".d2.none_locked"},  32'(d2_none),  32'd1);
    checkOutput({tag, ".d2.switch_pulse"}, 32'(d2_pulse), 32'd0);
    checkOutput({tag, ".d4.f_select"},     32'(d4_sel),   32'd0);
    checkOutput({tag, ".d4.none_locked"},  32'(d4_none),  32'd1);
  endtask

  initial begin
    bit [1:0] r2;
    bit [3:0] r4;
    rst_n   = 1'b0;
    locked2 = '0;
    locked4 = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    $display("[TB] idle with no locks");
    applyStimulus(2'b00, 4'b0000, 50);

    $display("[TB] source 0 acquisition");
    applyStimulus(2'b01, 4'b0000, 6);
    checkOutput("acq0.valid_before", 32'(d2_valid), 32'd0);
    applyStimulus(2'b01, 4'b0000, 1);
    checkOutput("acq0.f_select", 32'(d2_sel),   32'd0);
    checkOutput("acq0.valid",    32'(d2_valid), 32'd1);
    checkOutput("acq0.none",     32'(d2_none),  32'd0);
    checkOutput("acq0.pulse",    32'(d2_pulse), 32'd1);

    $display("[TB] short glitch on source 1");
    applyStimulus(2'b11, 4'b0000, 3);
    applyStimulus(2'b01, 4'b0000, 20);
    checkOutput("glitch.f_select", 32'(d2_sel), 32'd0);

    $display("[TB] higher-priority lock while running");
    applyStimulus(2'b11, 4'b0000, 7);
    checkOutput("revert.f_select", 32'(d2_sel),   REV ? 32'd1 : 32'd0);
    checkOutput("revert.pulse",    32'(d2_pulse), REV ? 32'd1 : 32'd0);
    applyStimulus(2'b10, 4'b0000, 20);
    checkOutput("lose0.f_select", 32'(d2_sel), 32'd1);
    applyStimulus(2'b00, 4'b0000, 3);
    checkOutput("lose_all.none", 32'(d2_none), 32'd1);
    applyStimulus(2'b00, 4'b0000, 10);

    $display("[TB] lock loss inside hold-off");
    applyStimulus(2'b11, 4'b0000, 7);
    checkOutput("both.f_select", 32'(d2_sel),   32'd1);
    checkOutput("both.pulse",    32'(d2_pulse), 32'd1);
    applyStimulus(2'b11, 4'b0000, 2);
    applyStimulus(2'b01, 4'b0000, 3);
    checkOutput("holdloss.f_select", 32'(d2_sel),   32'd0);
    checkOutput("holdloss.pulse",    32'(d2_pulse), 32'd1);
    applyStimulus(2'b00, 4'b0000, 3);
    checkOutput("holdloss.valid", 32'(d2_valid), 32'd0);
    checkOutput("holdloss.none",  32'(d2_none),  32'd1);
    applyStimulus(2'b00, 4'b0000, 10);

    $display("[TB] four-source priority");
    applyStimulus(2'b00, 4'b1011, 15);
    checkOutput("four.f_select", 32'(d4_sel), 32'd3);
    applyStimulus(2'b00, 4'b0011, 3);
    checkOutput("four.drop3", 32'(d4_sel),   32'd1);
    checkOutput("four.pulse", 32'(d4_pulse), 32'd1);
    applyStimulus(2'b00, 4'b0000, 10);

    $display("[TB] randomised lock activity");
    r2 = '0;
    r4 = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 7) == 0) r2[i] = ~r2[i];
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) r4[i] = ~r4[i];
      applyStimulus(r2, r4, 1);
    end

    $display("[TB] reset during hold-off");
    applyStimulus(2'b00, 4'b0000, 10);
    applyStimulus(2'b10, 4'b1000, 9);
    checkOutput("prereset.d2.f_select", 32'(d2_sel), 32'd1);
    checkOutput("prereset.d4.f_select", 32'(d4_sel), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    locked2 = '0;
    locked4 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(2'b00, 4'b0000, 10);
    applyStimulus(2'b01, 4'b0100, 12);
    checkOutput("reacq.d4.f_select", 32'(d4_sel), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
